// File: rtl/mult8_seq_nib.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 nibble core, four steps, valid/ready output.
// Optional MAC accumulator compiled in with `define MULT8_ACCUM_EN.
module mult8_seq_nib #(
    parameter int ACC_W = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prod,
    output logic        busy
`ifdef MULT8_ACCUM_EN
    ,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc_out
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends combinationally on ready, and in_ready/out_valid depend only on state.

    if (ACC_W < 16) begin : g_bad_acc_w
        $error("ACC_W must be at least 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  step;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] sum;
    logic [3:0]  nib_x;
    logic [3:0]  nib_y;
    logic [7:0]  pp;
    logic [3:0]  shamt;
    logic [15:0] sum_next;
    logic        accept;
    logic        handoff;

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = MUL;
            end
            MUL: begin
                if (step == 2'd3) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Step order: lo*lo, hi*lo, lo*hi, hi*hi; the two cross terms share shift 4.
    always_comb begin
        nib_x    = step[0] ? a_q[7:4] : a_q[3:0];
        nib_y    = step[1] ? b_q[7:4] : b_q[3:0];
        pp       = {4'b0, nib_x} * {4'b0, nib_y};
        shamt    = {step[1] & step[0], step[1] ^ step[0], 2'b00};
        sum_next = sum + ({8'b0, pp} << shamt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step     <= 2'd0;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            sum      <= 16'd0;
            out_prod <= 16'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept) begin
                a_q  <= in_a;
                b_q  <= in_b;
                sum  <= 16'd0;
                step <= 2'd0;
            end else if (state == MUL) begin
                sum  <= sum_next;
                step <= step + 2'd1;
                if (step == 2'd3) out_prod <= sum_next;
            end
        end
    end

`ifdef MULT8_ACCUM_EN
    logic clr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q   <= 1'b0;
            acc_out <= '0;
        end else begin
            if (state == IDLE && accept) clr_q <= acc_clr;
            if (handoff) acc_out <= (clr_q ? '0 : acc_out) + ACC_W'(out_prod);
        end
    end
`endif

endmodule
